// File: rtl/game_timer_pkg.sv
// Shared types and constants for the scoreboard game clock / shot clock.
// Counters hold two packed BCD digits: {tens, ones}.
package game_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_PERIOD_END,
    ST_GAME_OVER
  } state_t;

  localparam int BCD_W           = 4;
  localparam int DEF_PERIOD_MIN  = 10;
  localparam int DEF_SHOT_SEC    = 24;
  localparam int DEF_NUM_PERIODS = 4;

  // Binary 0..99 to packed two-digit BCD, used for elaboration-time reload values.
  function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned v);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = BCD_W'(v / 10);
    ones = BCD_W'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd2_down.sv
// Two-digit BCD down counter with synchronous load and enable.
// Decrementing 00 wraps to {TENS_MAX,9} and raises borrow_out for the next stage.
module bcd2_down
  import game_timer_pkg::*;
#(
  parameter int unsigned            TENS_MAX  = 9,
  parameter logic [2*BCD_W-1:0]     RESET_VAL = '0
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [2*BCD_W-1:0]   load_val,
  input  logic                 en,
  output logic [2*BCD_W-1:0]   value,
  output logic                 borrow_out,
  output logic                 is_zero
);

  logic [BCD_W-1:0] tens_reg;
  logic [BCD_W-1:0] ones_reg;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      tens_reg <= RESET_VAL[2*BCD_W-1:BCD_W];
      ones_reg <= RESET_VAL[BCD_W-1:0];
    end else if (load) begin
      tens_reg <= load_val[2*BCD_W-1:BCD_W];
      ones_reg <= load_val[BCD_W-1:0];
    end else if (en) begin
      if (ones_reg == '0) begin
        ones_reg <= BCD_W'(9);
        tens_reg <= (tens_reg == '0) ? BCD_W'(TENS_MAX) : tens_reg - BCD_W'(1);
      end else begin
        ones_reg <= ones_reg - BCD_W'(1);
      end
    end
  end

  assign value      = {tens_reg, ones_reg};
  assign is_zero    = (tens_reg == '0) && (ones_reg == '0);
  assign borrow_out = en && !load && is_zero;

endmodule

// File: rtl/game_timer.sv
// Basketball game clock (MM:SS), shot clock and period controller.
// All outputs come straight from registers; the FSM gates every counter update.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int PERIOD_MIN  = DEF_PERIOD_MIN,
  parameter int SHOT_SEC    = DEF_SHOT_SEC,
  parameter int NUM_PERIODS = DEF_NUM_PERIODS
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             start_stop,
  input  logic             shot_reset,
  input  logic             next_period,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] shot_tens,
  output logic [BCD_W-1:0] shot_ones,
  output logic [2:0]       period,
  output logic             running,
  output logic             period_end,
  output logic             shot_expired,
  output logic             game_over
);

  localparam logic [2*BCD_W-1:0] MIN_RELOAD  = to_bcd2(PERIOD_MIN);
  localparam logic [2*BCD_W-1:0] SHOT_RELOAD = to_bcd2(SHOT_SEC);
  localparam logic [2:0]         LAST_PERIOD = 3'(NUM_PERIODS);
  localparam logic [2*BCD_W-1:0] BCD_ONE     = 8'h01;

  state_t            state_reg, state_next;
  logic [2:0]        period_reg;
  logic              period_end_reg, shot_expired_reg;
  logic [2*BCD_W-1:0] sec_val, min_val, shot_val;
  logic              sec_zero, min_zero, shot_zero;
  logic              sec_borrow, min_borrow, shot_borrow;
  logic              unused_borrows;

  logic run_tick, shot_reload_ok, game_hit, shot_en, shot_hit, advance;

  assign run_tick       = (state_reg == ST_RUNNING) && tick;
  assign shot_reload_ok = shot_reset && (state_reg inside {ST_IDLE, ST_RUNNING, ST_PAUSED});
  assign game_hit       = run_tick && min_zero && (sec_val == BCD_ONE);
  // A reload on the same cycle as a tick suppresses the decrement (and any expiry).
  assign shot_en        = run_tick && !shot_zero && !shot_reload_ok;
  assign shot_hit       = shot_en && (shot_val == BCD_ONE);
  assign advance        = (state_reg == ST_PERIOD_END) && next_period && (period_reg < LAST_PERIOD);

  bcd2_down #(.TENS_MAX(5), .RESET_VAL(8'h00)) u_sec (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .load      (advance),
    .load_val  (8'h00),
    .en        (run_tick && !(sec_zero && min_zero)),
    .value     (sec_val),
    .borrow_out(sec_borrow),
    .is_zero   (sec_zero)
  );

  bcd2_down #(.TENS_MAX(9), .RESET_VAL(MIN_RELOAD)) u_min (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .load      (advance),
    .load_val  (MIN_RELOAD),
    .en        (sec_borrow),
    .value     (min_val),
    .borrow_out(min_borrow),
    .is_zero   (min_zero)
  );

  // End of period forces the shot clock to 00, overriding a simultaneous reload.
  bcd2_down #(.TENS_MAX(9), .RESET_VAL(SHOT_RELOAD)) u_shot (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .load      (advance || shot_reload_ok || game_hit),
    .load_val  (game_hit ? 8'h00 : SHOT_RELOAD),
    .en        (shot_en),
    .value     (shot_val),
    .borrow_out(shot_borrow),
    .is_zero   (shot_zero)
  );

  assign unused_borrows = min_borrow | shot_borrow;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_PAUSED: if (start_stop) state_next = ST_RUNNING;
      ST_RUNNING: begin
        if (game_hit)                   state_next = ST_PERIOD_END;
        else if (shot_hit || start_stop) state_next = ST_PAUSED;
      end
      ST_PERIOD_END: if (next_period) state_next = advance ? ST_IDLE : ST_GAME_OVER;
      ST_GAME_OVER: state_next = ST_GAME_OVER;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      period_reg       <= 3'd1;
      period_end_reg   <= 1'b0;
      shot_expired_reg <= 1'b0;
    end else begin
      period_end_reg   <= game_hit;
      shot_expired_reg <= shot_hit;
      if (advance) period_reg <= period_reg + 3'd1;
    end
  end

  assign {min_tens, min_ones}   = min_val;
  assign {sec_tens, sec_ones}   = sec_val;
  assign {shot_tens, shot_ones} = shot_val;
  assign period       = period_reg;
  assign running      = (state_reg == ST_RUNNING);
  assign game_over    = (state_reg == ST_GAME_OVER);
  assign period_end   = period_end_reg;
  assign shot_expired = shot_expired_reg;

endmodule

// File: doc/game_timer.md
# game_timer

Countdown game-clock and shot-clock controller for the basketball scoreboard. Consumes the one-cycle 1 Hz tick derived from the 50 MHz divider stage. Holds period time (MM:SS), 24 s shot clock and period number as BCD digits for the 7-segment driver stage. Start/pause, shot-clock reload and period advance come from debounced, single-cycle button pulses.

## Interface
- PERIOD_MIN, 10, period length in minutes (1–99)
- SHOT_SEC, 24, shot-clock reload value in seconds (1–99)
- NUM_PERIODS, 4, periods per game (1–7)

- clock_in  in  1  50 MHz system clock
- reset_n  in  1  reset; asynchronous, active-low
- tick  in  1  one-cycle pulse, 1 Hz, synchronous to clock_in
- start_stop  in  1  one-cycle pulse; toggles run/pause
- shot_reset  in  1  one-cycle pulse; reload shot clock to SHOT_SEC
- next_period  in  1  one-cycle pulse; advance to next period
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  game clock, BCD
- shot_tens, shot_ones  out  4 each  shot clock, BCD
- period  out  3  current period, binary, 1..NUM_PERIODS
- running  out  1  high in RUNNING
- period_end  out  1  one-cycle pulse when game clock reaches 00:00
- shot_expired  out  1  one-cycle pulse when shot clock reaches 00
- game_over  out  1  level, high in GAME_OVER

## Operation
- States: IDLE, RUNNING, PAUSED, PERIOD_END, GAME_OVER.
- Reset: IDLE; game clock = PERIOD_MIN:00; shot = SHOT_SEC; period = 1; running, period_end, shot_expired, game_over = 0.
- IDLE/PAUSED + start_stop → RUNNING. RUNNING + start_stop → PAUSED.
- RUNNING + tick: game clock decrements by 1 s in BCD (sec_ones 0→9 borrow; sec 00→59 borrow from minutes); shot clock decrements by 1.
- Shot clock reaches 00 on a tick: shot_expired pulses; state → PAUSED; shot holds 00 until shot_reset.
- Game clock reaches 00:00 on a tick: period_end pulses; state → PERIOD_END; shot clock forced to 00.
- Both reach zero on the same tick: both pulses; state → PERIOD_END.
- shot_reset: accepted in IDLE, RUNNING, PAUSED; shot = SHOT_SEC. Ignored in PERIOD_END, GAME_OVER.
- shot_reset and tick in the same cycle: reload wins, no decrement.
- start_stop and tick in the same cycle in RUNNING: decrement applied, then PAUSED.
- PERIOD_END + next_period: if period < NUM_PERIODS, period+1, reload game clock and shot, → IDLE; else → GAME_OVER.
- next_period outside PERIOD_END: ignored. start_stop in PERIOD_END/GAME_OVER: ignored.
- GAME_OVER: absorbing; all values frozen; exit only by reset_n.
- Ticks outside RUNNING: ignored.
- Counters never underflow: 00:00 and shot 00 are floors.

## Timing
- All outputs registered. Tick at cycle N → new digits and any pulse valid at N+1.
- period_end and shot_expired are high for exactly one clock_in cycle.
- Command pulses take effect on the next edge; running reflects the new state at N+1.
- reset_n assertion mid-count clears immediately (async). Deassertion is synchronous to clock_in; the first accepted command is on the edge after release.

## Structure
- Shared package game_timer_pkg: state enum, BCD digit width (4), default constants PERIOD_MIN/SHOT_SEC/NUM_PERIODS, BCD encoding helper for reload values.
- One sub-module, bcd2_down: 2-digit BCD down counter with load, enable, configurable tens-wrap (5 for seconds, 9 otherwise), borrow_out and is_zero. Instantiated three times: seconds, minutes, shot.

## Test plan
- Reset, start_stop, 3 ticks → 09:57, shot 21, running=1, period=1.
- Load from 10:00, run 24 ticks with no shot_reset → shot_expired pulse at tick 24, state PAUSED, game clock 09:36, shot 00.
- shot_reset in the same cycle as a tick at shot 05 → shot 24, game clock still decrements.
- PERIOD_MIN=1: run 60 ticks with shot_reset every 20 → 00:00, single period_end pulse; next_period → period 2, 01:00, shot 24, IDLE.
- NUM_PERIODS=1: expire the period, then next_period → game_over=1; further ticks, start_stop and shot_reset change nothing.
- Assert reset_n while RUNNING at 04:17 → immediate 10:00, shot 24, period 1, running=0.
